// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port, fixed-latency unified memory between the
//   instruction-fetch port (IF, read-only) and the data port (D, load/store).
//   Each access is sequenced for LAT cycles, the read data is returned to the
//   winning requester with a one-cycle ready pulse, and a pipeline hold is
//   raised while any request is outstanding. Data has priority over fetch.
//
// Parameters:
//   LAT    memory read latency in cycles (1..15): first cycle of mem_en to the
//          cycle mem_rdata is valid
//   CNT_W  width of the performance counters (optional feature only)
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   if_req/if_addr      fetch request and address, held until if_ready
//   if_ready/if_rdata   one-cycle completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata   data request, held until d_ready
//   d_ready/d_rdata     one-cycle completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata   registered memory controls
//   mem_rdata           memory read data, valid in the last access cycle
//   hold                combinational pipeline freeze request
//   busy                high while an access is in flight
//   perf_hold_cyc/perf_if_cnt/perf_d_cnt   only when ARB_PERF_CNT_EN is defined
//
// Optional feature macro: ARB_PERF_CNT_EN
//   Adds three free-running CNT_W-bit counters: hold cycles, fetch
//   completions and data completions. All clear on reset and wrap.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned LAT   = 2,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_req,
   input  logic [31:0]      if_addr,
   output logic             if_ready,
   output logic [31:0]      if_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [31:0]      d_addr,
   input  logic [31:0]      d_wdata,
   output logic             d_ready,
   output logic [31:0]      d_rdata,
   output logic             mem_en,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
`ifdef ARB_PERF_CNT_EN
   output logic [CNT_W-1:0] perf_hold_cyc,
   output logic [CNT_W-1:0] perf_if_cnt,
   output logic [CNT_W-1:0] perf_d_cnt,
`endif
   output logic             hold,
   output logic             busy
);

   if (LAT < 1 || LAT > 15 || CNT_W < 1) begin : g_param_check
      $error("mem_port_arbiter: LAT must be 1..15 and CNT_W at least 1");
   end

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   // Cycles remaining after the first access cycle; zero marks the completion cycle.
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_e      state_q;
   owner_e      owner_q;
   logic [3:0]  cnt_q;
   logic        if_ready_q;
   logic        d_ready_q;
   logic [31:0] if_rdata_q;
   logic [31:0] d_rdata_q;
   logic        mem_en_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;

   logic        done_s;
   logic        grant_s;
   logic        grant_d_s;

   // Decide whether the coming edge completes the access and who is granted next
   always_comb begin
      done_s    = 1'b0;
      grant_s   = 1'b0;
      grant_d_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (d_req) begin
               grant_s   = 1'b1;
               grant_d_s = 1'b1;
            end else if (if_req) begin
               grant_s   = 1'b1;
            end else begin
               grant_s   = 1'b0;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               done_s = 1'b1;
               // Only the other port may chain in: the port just served still
               // holds req until it sees its ready pulse.
               case (owner_q)
                  OWN_D: begin
                     grant_s   = if_req;
                  end
                  OWN_IF: begin
                     grant_s   = d_req;
                     grant_d_s = d_req;
                  end
                  default: begin
                     grant_s   = 1'b0;
                  end
               endcase
            end else begin
               done_s = 1'b0;
            end
         end
         default: begin
            done_s = 1'b0;
         end
      endcase
   end

   // Arbitration FSM with all memory-side and requester-side outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_NONE;
         cnt_q       <= 4'd0;
         if_ready_q  <= 1'b0;
         d_ready_q   <= 1'b0;
         if_rdata_q  <= 32'h0000_0000;
         d_rdata_q   <= 32'h0000_0000;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0000_0000;
         mem_wdata_q <= 32'h0000_0000;
      end else begin
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;

         if (done_s) begin
            case (owner_q)
               OWN_IF: begin
                  if_rdata_q <= mem_rdata;
                  if_ready_q <= 1'b1;
               end
               OWN_D: begin
                  d_ready_q <= 1'b1;
                  // A store completes without disturbing the last load result
                  if (!mem_we_q) begin
                     d_rdata_q <= mem_rdata;
                  end
               end
               default: begin
                  if_ready_q <= 1'b0;
               end
            endcase
         end

         if (grant_s) begin
            state_q  <= ST_ACCESS;
            cnt_q    <= CNT_INIT;
            mem_en_q <= 1'b1;
            if (grant_d_s) begin
               owner_q     <= OWN_D;
               mem_addr_q  <= d_addr;
               mem_we_q    <= d_we;
               mem_wdata_q <= d_wdata;
            end else begin
               owner_q     <= OWN_IF;
               mem_addr_q  <= if_addr;
               mem_we_q    <= 1'b0;
            end
         end else if (done_s) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_NONE;
            cnt_q    <= 4'd0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
         end else if (state_q == ST_ACCESS) begin
            cnt_q <= cnt_q - 4'd1;
         end else begin
            cnt_q <= 4'd0;
         end
      end
   end

   assign if_ready  = if_ready_q;
   assign d_ready   = d_ready_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q == ST_ACCESS);
   // A requester stops stalling the pipe in its own ready cycle
   assign hold      = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

`ifdef ARB_PERF_CNT_EN
   localparam logic [CNT_W-1:0] PERF_ONE = CNT_W'(1'b1);

   logic [CNT_W-1:0] perf_hold_q;
   logic [CNT_W-1:0] perf_if_q;
   logic [CNT_W-1:0] perf_d_q;

   // Performance counters: hold cycles and completions per port, wrapping
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_hold_q <= {CNT_W{1'b0}};
         perf_if_q   <= {CNT_W{1'b0}};
         perf_d_q    <= {CNT_W{1'b0}};
      end else begin
         if (hold) begin
            perf_hold_q <= perf_hold_q + PERF_ONE;
         end else begin
            perf_hold_q <= perf_hold_q;
         end
         if (if_ready_q) begin
            perf_if_q <= perf_if_q + PERF_ONE;
         end else begin
            perf_if_q <= perf_if_q;
         end
         if (d_ready_q) begin
            perf_d_q <= perf_d_q + PERF_ONE;
         end else begin
            perf_d_q <= perf_d_q;
         end
      end
   end

   assign perf_hold_cyc = perf_hold_q;
   assign perf_if_cnt   = perf_if_q;
   assign perf_d_cnt    = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-timeline reference model.
module tb_mem_port_arbiter;

   localparam int unsigned LAT   = 2;
   localparam int unsigned CNT_W = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic        if_ready, d_ready, mem_en, mem_we, hold, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

   logic        l1_if_req, l1_d_req, l1_d_we;
   logic [31:0] l1_if_addr, l1_d_addr, l1_d_wdata, l1_mem_rdata;
   logic        l1_if_ready, l1_d_ready, l1_mem_en, l1_mem_we, l1_hold, l1_busy;
   logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;

`ifdef ARB_PERF_CNT_EN
   logic [CNT_W-1:0] perf_hold_cyc, perf_if_cnt, perf_d_cnt;
   logic [CNT_W-1:0] l1_perf_hold_cyc, l1_perf_if_cnt, l1_perf_d_cnt;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(.LAT(LAT), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
`ifdef ARB_PERF_CNT_EN
      .perf_hold_cyc(perf_hold_cyc), .perf_if_cnt(perf_if_cnt), .perf_d_cnt(perf_d_cnt),
`endif
      .hold(hold), .busy(busy)
   );

   mem_port_arbiter #(.LAT(1), .CNT_W(CNT_W)) u_dut_lat1 (
      .clk(clk), .reset(reset),
      .if_req(l1_if_req), .if_addr(l1_if_addr), .if_ready(l1_if_ready), .if_rdata(l1_if_rdata),
      .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
      .d_ready(l1_d_ready), .d_rdata(l1_d_rdata),
      .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
      .mem_rdata(l1_mem_rdata),
`ifdef ARB_PERF_CNT_EN
      .perf_hold_cyc(l1_perf_hold_cyc), .perf_if_cnt(l1_perf_if_cnt), .perf_d_cnt(l1_perf_d_cnt),
`endif
      .hold(l1_hold), .busy(l1_busy)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: one access timeline in cycle numbers
   bit          acc_valid;
   bit          acc_is_d;
   int          acc_grant;
   logic        acc_we;
   logic [31:0] acc_addr, acc_wdata;
   logic [31:0] exp_addr, exp_wdata, exp_if_rdata, exp_d_rdata;
   int          if_rdy_at, d_rdy_at;
   logic [31:0] shadow   [logic [31:0]];
   logic [31:0] macro_mem[logic [31:0]];
   int          win_pos;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] shadow_rd(input logic [31:0] a);
      return shadow.exists(a) ? shadow[a] : init_word(a);
   endfunction

   function automatic logic [31:0] macro_rd(input logic [31:0] a);
      return macro_mem.exists(a) ? macro_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] rnd_addr();
      return 32'h0000_0100 + 32'($urandom_range(0, 3)) * 32'd4;
   endfunction

   task automatic model_reset();
      acc_valid    = 1'b0;
      if_rdy_at    = -1;
      d_rdy_at     = -1;
      exp_if_rdata = 32'h0;
      exp_d_rdata  = 32'h0;
      exp_addr     = 32'h0;
      exp_wdata    = 32'h0;
   endtask

   // Apply the arbitration rules for the edge that ends cycle 'cyc'
   task automatic model_edge();
      bit done, gi, gd;
      done = acc_valid && (cyc == acc_grant + int'(LAT));
      gi = 1'b0;
      gd = 1'b0;
      if (!acc_valid) begin
         if (d_req) gd = 1'b1;
         else if (if_req) gi = 1'b1;
      end else if (done) begin
         if (acc_is_d) gi = if_req;
         else gd = d_req;
      end
      if (done) begin
         if (acc_is_d) begin
            d_rdy_at = cyc + 1;
            if (acc_we) shadow[acc_addr] = acc_wdata;
            else exp_d_rdata = shadow_rd(acc_addr);
         end else begin
            if_rdy_at    = cyc + 1;
            exp_if_rdata = shadow_rd(acc_addr);
         end
         acc_valid = 1'b0;
      end
      if (gd) begin
         acc_valid = 1'b1; acc_is_d = 1'b1; acc_grant = cyc;
         acc_we = d_we; acc_addr = d_addr; acc_wdata = d_wdata;
         exp_addr = d_addr; exp_wdata = d_wdata;
      end else if (gi) begin
         acc_valid = 1'b1; acc_is_d = 1'b0; acc_grant = cyc;
         acc_we = 1'b0; acc_addr = if_addr;
         exp_addr = if_addr;
      end
   endtask

   // Finish the current cycle (hold check, model), clock, then check the new cycle
   task automatic tick();
      #1;
      chk("hold", hold, (if_req && cyc != if_rdy_at) || (d_req && cyc != d_rdy_at));
      if (reset) model_reset();
      else model_edge();
      @(posedge clk);
      #1;
      cyc++;
      if (mem_en) win_pos = (win_pos >= int'(LAT)) ? 1 : win_pos + 1;
      else win_pos = 0;
      if (win_pos == int'(LAT)) begin
         mem_rdata = macro_rd(mem_addr);
         if (mem_we) macro_mem[mem_addr] = mem_wdata;
      end else begin
         mem_rdata = 32'hBAD0_0000 ^ 32'(cyc);
      end
      chk("if_ready",  if_ready,  cyc == if_rdy_at);
      chk("d_ready",   d_ready,   cyc == d_rdy_at);
      chk("if_rdata",  if_rdata,  exp_if_rdata);
      chk("d_rdata",   d_rdata,   exp_d_rdata);
      chk("mem_en",    mem_en,    acc_valid);
      chk("busy",      busy,      acc_valid);
      chk("mem_we",    mem_we,    acc_valid && acc_we);
      chk("mem_addr",  mem_addr,  exp_addr);
      chk("mem_wdata", mem_wdata, exp_wdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
      d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
      l1_if_req = 1'b0; l1_if_addr = 32'h0; l1_d_req = 1'b0; l1_d_we = 1'b0;
      l1_d_addr = 32'h0; l1_d_wdata = 32'h0; l1_mem_rdata = 32'hA1B2_C3D4;
      win_pos = 0;
      model_reset();
      macro_mem[32'h0040_0000] = 32'h8C08_0004; shadow[32'h0040_0000] = 32'h8C08_0004;
      macro_mem[32'h0000_0020] = 32'h1234_5678; shadow[32'h0000_0020] = 32'h1234_5678;

      @(posedge clk);
      #1;
      tick();
      chk("rst_if_ready", if_ready, 1'b0);  chk("rst_d_ready", d_ready, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0); chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0); chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_hold", hold, 1'b0);          chk("rst_busy", busy, 1'b0);
      reset = 1'b0;
      tick();

      // Scenario 1: single fetch
      if_req = 1'b1; if_addr = 32'h0040_0000;
      tick(); chk("s1_en_c1", mem_en, 1'b1); chk("s1_we_c1", mem_we, 1'b0);
      tick(); chk("s1_en_c2", mem_en, 1'b1); chk("s1_hold_c2", hold, 1'b1);
      tick(); chk("s1_rdy_c3", if_ready, 1'b1); chk("s1_rdata", if_rdata, 32'h8C08_0004);
      chk("s1_hold_c3", hold, 1'b0); chk("s1_en_c3", mem_en, 1'b0);
      if_req = 1'b0;
      tick(); chk("s1_rdy_c4", if_ready, 1'b0);

      // Scenario 2: simultaneous store and fetch, data first, no gap
      reset = 1'b1; tick(); reset = 1'b0;
      if_req = 1'b1; if_addr = 32'h0040_0004;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
      tick(); chk("s2_en_c1", mem_en, 1'b1); chk("s2_we_c1", mem_we, 1'b1);
      chk("s2_wd_c1", mem_wdata, 32'hDEAD_BEEF); chk("s2_addr_c1", mem_addr, 32'h10);
      tick();
      tick(); chk("s2_drdy_c3", d_ready, 1'b1); chk("s2_en_c3", mem_en, 1'b1);
      chk("s2_addr_c3", mem_addr, 32'h0040_0004); chk("s2_we_c3", mem_we, 1'b0);
      d_req = 1'b0;
      tick(); chk("s2_en_c4", mem_en, 1'b1);
      tick(); chk("s2_irdy_c5", if_ready, 1'b1); chk("s2_en_c5", mem_en, 1'b0);
      if_req = 1'b0;
      tick();
`ifdef ARB_PERF_CNT_EN
      chk("perf_hold_cyc", perf_hold_cyc, 32'd5);
      chk("perf_if_cnt", perf_if_cnt, 32'd1);
      chk("perf_d_cnt", perf_d_cnt, 32'd1);
`endif

      // Scenario 3: load then a store that must not disturb d_rdata
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      tick(); tick();
      tick(); chk("s3_drdy_c3", d_ready, 1'b1); chk("s3_rdata_c3", d_rdata, 32'h1234_5678);
      d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'hCAFE_F00D;
      tick(); chk("s3_en_c4", mem_en, 1'b1); chk("s3_we_c4", mem_we, 1'b1);
      tick();
      tick(); chk("s3_drdy_c6", d_ready, 1'b1); chk("s3_rdata_c6", d_rdata, 32'h1234_5678);
      d_req = 1'b0;
      tick();

      // Scenario 4: reset in the middle of a fetch
      if_req = 1'b1; if_addr = 32'h40;
      tick(); tick();
      reset = 1'b1; if_req = 1'b0;
      tick();
      chk("s4_en", mem_en, 1'b0);           chk("s4_we", mem_we, 1'b0);
      chk("s4_irdy", if_ready, 1'b0);       chk("s4_busy", busy, 1'b0);
      chk("s4_hold", hold, 1'b0);           chk("s4_addr", mem_addr, 32'h0);
      chk("s4_if_rdata", if_rdata, 32'h0);  chk("s4_d_rdata", d_rdata, 32'h0);
      reset = 1'b0;
      tick(); chk("s4_irdy_after", if_ready, 1'b0);
      tick();

      // Scenario 5: req dropped while owning the access still completes
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
      tick(); d_req = 1'b0;
      tick();
      tick(); chk("s5_drdy", d_ready, 1'b1); chk("s5_rdata", d_rdata, init_word(32'h30));
      tick();

      // Randomized traffic: requesters hold until ready, then drop or re-request
      for (int k = 0; k < 400; k++) begin
         if (if_req && if_ready) begin
            if ($urandom_range(0, 1) == 0) if_req = 1'b0;
            else if_addr = rnd_addr();
         end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = rnd_addr();
         end
         if (d_req && d_ready) begin
            if ($urandom_range(0, 1) == 0) d_req = 1'b0;
            else begin
               d_addr = rnd_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end
         end else if (!d_req) begin
            d_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
               d_req = 1'b1; d_addr = rnd_addr(); d_wdata = $urandom;
            end
         end
         tick();
      end
      for (int k = 0; k < 12; k++) begin
         if (if_req && if_ready) if_req = 1'b0;
         if (d_req && d_ready) d_req = 1'b0;
         tick();
      end
      chk("drain_busy", busy, 1'b0);

      // LAT=1 instance: continuous loads alternate access and ready cycles
      l1_d_req = 1'b1; l1_d_we = 1'b0; l1_d_addr = 32'h80;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("l1_mem_en", l1_mem_en, (k % 2) == 1);
         chk("l1_busy", l1_busy, (k % 2) == 1);
         chk("l1_d_ready", l1_d_ready, (k % 2) == 0);
         chk("l1_hold", l1_hold, (k % 2) == 1);
         if (k == 2) chk("l1_d_rdata", l1_d_rdata, 32'hA1B2_C3D4);
      end
      l1_d_req = 1'b0;
      tick();
      chk("l1_en_end", l1_mem_en, 1'b0);
      chk("l1_rdy_end", l1_d_ready, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
